branch_pc_unit: RTL and testbench

Owns the program counter of the single-cycle RV32I core and sits directly downstream of the comparator: it consumes the six signed/unsigned gt/eq/lt flags together with the instruction's funct3 and control bits, decides branch taken/not-taken, and computes the next PC. It also handles JAL/JALR targets, detects misaligned targets and illegal branch funct3 with a trap/acknowledge handshake, and keeps retired-branch and taken-branch counters.

---
 rtl/rv32i_pkg.sv | 18 +
 rtl/branch_cond.sv | 27 ++
 rtl/branch_pc_unit.sv | 97 +++++++++
 tb/tb_branch_pc_unit.sv | 137 +++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared branch funct3 encodings, trap causes and PC FSM states
package rv32i_pkg;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MISALIGN = 2'd1,
    CAUSE_ILLEGAL  = 2'd2
  } trap_cause_t;
  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } pc_state_t;
endpackage

// File: rtl/branch_cond.sv
// branch_cond: maps funct3 and comparator flags to a branch condition and an illegal-encoding flag
module branch_cond
  import rv32i_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       gt_u,
  input  logic       eq_u,
  input  logic       lt_u,
  input  logic       gt_s,
  input  logic       eq_s,
  input  logic       lt_s,
  output logic       cond,
  output logic       illegal
);
  // Every RV32I condition is expressible with eq_s, lt_s and lt_u alone
  logic unused_flags;
  assign unused_flags = ^{gt_u, eq_u, gt_s};
  always_comb begin
    cond = (funct3 == F3_BEQ)  ? eq_s  :
           (funct3 == F3_BNE)  ? !eq_s :
           (funct3 == F3_BLT)  ? lt_s  :
           (funct3 == F3_BGE)  ? !lt_s :
           (funct3 == F3_BLTU) ? lt_u  :
           (funct3 == F3_BGEU) ? !lt_u : 1'b0;
    illegal = (funct3[2:1] == 2'b01);
  end
endmodule

// File: rtl/branch_pc_unit.sv
// branch_pc_unit: PC register, branch/jump target selection, fault trapping and branch counters
module branch_pc_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic [2:0]  funct3,
  input  logic        gt_u,
  input  logic        eq_u,
  input  logic        lt_u,
  input  logic        gt_s,
  input  logic        eq_s,
  input  logic        lt_s,
  input  logic [31:0] rs1,
  input  logic [31:0] imm,
  input  logic        trap_ack,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        taken,
  output logic        trap_valid,
  output logic [1:0]  trap_cause,
  output logic [31:0] trap_epc,
  output logic [31:0] br_count,
  output logic [31:0] taken_count
);
  pc_state_t   state_q, state_d;
  trap_cause_t cause_q, cause_d, fault_cause;
  logic [31:0] pc_q, pc_d, epc_q, epc_d, br_count_q, br_count_d, taken_count_q, taken_count_d;
  logic [31:0] target, next_pc;
  logic        cond, illegal, misaligned, fault, retire, trap_enter, trap_exit;
  branch_cond u_cond (
    .funct3 (funct3),
    .gt_u   (gt_u),
    .eq_u   (eq_u),
    .lt_u   (lt_u),
    .gt_s   (gt_s),
    .eq_s   (eq_s),
    .lt_s   (lt_s),
    .cond   (cond),
    .illegal(illegal)
  );
  always_comb begin
    pc_plus4    = pc_q + 32'd4;
    target      = is_jalr ? ((rs1 + imm) & ~32'h1) : (pc_q + imm);
    taken       = (is_branch & cond & ~illegal) | is_jal | is_jalr;
    next_pc     = taken ? target : pc_plus4;
    misaligned  = taken & (target[1:0] != 2'b00);
    fault       = misaligned | (is_branch & illegal);
    fault_cause = misaligned ? CAUSE_MISALIGN : CAUSE_ILLEGAL;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      cause_q       <= CAUSE_NONE;
      epc_q         <= 32'h0;
      br_count_q    <= 32'h0;
      taken_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      cause_q       <= cause_d;
      epc_q         <= epc_d;
      br_count_q    <= br_count_d;
      taken_count_q <= taken_count_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (state_q == RUN && en && fault) state_d = TRAP;
    if (state_q == TRAP && trap_ack) state_d = RUN;
  end
  // A faulting instruction never retires, so the PC and counters freeze until the handler acks
  always_comb begin
    retire        = (state_q == RUN) & en & ~fault;
    trap_enter    = (state_q == RUN) & en & fault;
    trap_exit     = (state_q == TRAP) & trap_ack;
    pc_d          = trap_exit ? TRAP_VEC : retire ? next_pc : pc_q;
    cause_d       = trap_enter ? fault_cause : trap_exit ? CAUSE_NONE : cause_q;
    epc_d         = trap_enter ? pc_q : epc_q;
    br_count_d    = br_count_q + {31'b0, retire & is_branch};
    taken_count_d = taken_count_q + {31'b0, retire & is_branch & taken};
  end
  assign pc          = pc_q;
  assign trap_valid  = (state_q == TRAP);
  assign trap_cause  = cause_q;
  assign trap_epc    = epc_q;
  assign br_count    = br_count_q;
  assign taken_count = taken_count_q;
endmodule

// File: tb/tb_branch_pc_unit.sv
// tb_branch_pc_unit: directed scoreboard bench for branch_pc_unit
module tb_branch_pc_unit;
  logic        clk = 1'b0, rst, en, is_branch, is_jal, is_jalr, trap_ack;
  logic [2:0]  funct3;
  logic        gt_u, eq_u, lt_u, gt_s, eq_s, lt_s;
  logic [31:0] rs1, imm, pc, pc_plus4, trap_epc, br_count, taken_count;
  logic        taken, trap_valid;
  logic [1:0]  trap_cause;
  int checks = 0, errors = 0;
  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        tv;
    logic [1:0]  cause;
    logic [31:0] epc;
    logic [31:0] br;
    logic [31:0] tk;
  } exp_t;
  exp_t sb[$];
  localparam logic [5:0] NONE = 6'b000000, EQ = 6'b010010, LTS = 6'b000001,
                         LTU = 6'b001000, GT = 6'b100100;
  branch_pc_unit dut (
    .clk(clk), .rst(rst), .en(en), .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
    .funct3(funct3), .gt_u(gt_u), .eq_u(eq_u), .lt_u(lt_u), .gt_s(gt_s), .eq_s(eq_s), .lt_s(lt_s),
    .rs1(rs1), .imm(imm), .trap_ack(trap_ack), .pc(pc), .pc_plus4(pc_plus4), .taken(taken),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_epc(trap_epc),
    .br_count(br_count), .taken_count(taken_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drv(input logic e, input logic b, input logic j, input logic jr, input logic [2:0] f3,
                     input logic [5:0] fl, input logic [31:0] r1, input logic [31:0] im, input logic ack);
    en = e; is_branch = b; is_jal = j; is_jalr = jr; funct3 = f3;
    {gt_u, eq_u, lt_u, gt_s, eq_s, lt_s} = fl;
    rs1 = r1; imm = im; trap_ack = ack;
    #1;
  endtask
  task automatic expect_st(input string tag, input logic [31:0] p, input logic tv, input logic [1:0] c,
                           input logic [31:0] epc, input logic [31:0] br, input logic [31:0] tk);
    sb.push_back('{tag, p, tv, c, epc, br, tk});
  endtask
  task automatic tick;
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) chk("scoreboard_empty", 32'd0, 32'd1);
    else begin
      e = sb.pop_front();
      chk({e.tag, ".pc"}, pc, e.pc);
      chk({e.tag, ".trap_valid"}, {31'b0, trap_valid}, {31'b0, e.tv});
      chk({e.tag, ".trap_cause"}, {30'b0, trap_cause}, {30'b0, e.cause});
      chk({e.tag, ".trap_epc"}, trap_epc, e.epc);
      chk({e.tag, ".br_count"}, br_count, e.br);
      chk({e.tag, ".taken_count"}, taken_count, e.tk);
    end
  endtask
  initial begin
    rst = 1'b1;
    drv(0, 0, 0, 0, 3'b000, NONE, 0, 0, 0);
    expect_st("reset", 32'h0, 0, 0, 0, 0, 0); tick;
    rst = 1'b0;
    drv(1, 0, 0, 0, 3'b000, NONE, 0, 0, 0);
    chk("nop_taken", {31'b0, taken}, 0);
    expect_st("seq1", 32'h4, 0, 0, 0, 0, 0); tick;
    expect_st("seq2", 32'h8, 0, 0, 0, 0, 0); tick;
    drv(1, 0, 0, 0, 3'b000, NONE, 0, 0, 1);
    expect_st("seq3_ack_ignored", 32'hC, 0, 0, 0, 0, 0); tick;
    drv(1, 0, 1, 0, 3'b000, NONE, 0, 32'hF4, 0);
    chk("jal_taken", {31'b0, taken}, 1);
    expect_st("jal_to_100", 32'h100, 0, 0, 0, 0, 0); tick;
    drv(1, 1, 0, 0, 3'b000, EQ, 0, 32'h20, 0);
    chk("beq_taken", {31'b0, taken}, 1);
    expect_st("beq", 32'h120, 0, 0, 0, 1, 1); tick;
    drv(1, 0, 1, 0, 3'b000, NONE, 0, 32'hFFFF_FFE0, 0);
    expect_st("jal_back", 32'h100, 0, 0, 0, 1, 1); tick;
    drv(1, 1, 0, 0, 3'b001, EQ, 0, 32'h20, 0);
    chk("bne_taken", {31'b0, taken}, 0);
    expect_st("bne", 32'h104, 0, 0, 0, 2, 1); tick;
    drv(1, 0, 0, 1, 3'b000, NONE, 32'h1003, 32'h2, 0);
    chk("jalr_taken", {31'b0, taken}, 1);
    expect_st("jalr_1004", 32'h1004, 0, 0, 0, 2, 1); tick;
    drv(1, 0, 0, 1, 3'b000, NONE, 32'h1001, 32'h0, 0);
    expect_st("jalr_bit0_cleared", 32'h1000, 0, 0, 0, 2, 1); tick;
    drv(1, 0, 1, 0, 3'b000, NONE, 0, 32'hFFFF_F200, 0);
    expect_st("jal_to_200", 32'h200, 0, 0, 0, 2, 1); tick;
    drv(1, 0, 1, 0, 3'b000, NONE, 0, 32'h6, 0);
    expect_st("misalign_trap", 32'h200, 1, 1, 32'h200, 2, 1); tick;
    expect_st("trap_held", 32'h200, 1, 1, 32'h200, 2, 1); tick;
    drv(0, 0, 0, 0, 3'b000, NONE, 0, 0, 1);
    expect_st("trap_ack", 32'h100, 0, 0, 32'h200, 2, 1); tick;
    drv(1, 1, 0, 0, 3'b010, EQ, 0, 32'h20, 0);
    chk("illegal_taken", {31'b0, taken}, 0);
    expect_st("illegal_trap", 32'h100, 1, 2, 32'h100, 2, 1); tick;
    rst = 1'b1;
    expect_st("reset_mid_trap", 32'h0, 0, 0, 0, 0, 0); tick;
    rst = 1'b0;
    drv(0, 1, 0, 0, 3'b000, EQ, 0, 32'h40, 0);
    chk("stall_taken", {31'b0, taken}, 1);
    expect_st("stall", 32'h0, 0, 0, 0, 0, 0); tick;
    drv(0, 1, 0, 0, 3'b101, LTS, 0, 32'h8, 0); chk("bge_lt", {31'b0, taken}, 0);
    drv(0, 1, 0, 0, 3'b110, LTU, 0, 32'h8, 0); chk("bltu_lt", {31'b0, taken}, 1);
    drv(0, 1, 0, 0, 3'b111, LTU, 0, 32'h8, 0); chk("bgeu_lt", {31'b0, taken}, 0);
    drv(0, 1, 0, 0, 3'b111, GT, 0, 32'h8, 0);  chk("bgeu_gt", {31'b0, taken}, 1);
    drv(0, 1, 0, 0, 3'b100, GT, 0, 32'h8, 0);  chk("blt_gt", {31'b0, taken}, 0);
    drv(0, 1, 0, 0, 3'b011, EQ, 0, 32'h8, 0);  chk("f3_011", {31'b0, taken}, 0);
    drv(1, 1, 0, 0, 3'b100, LTS, 0, 32'h8, 0);
    expect_st("blt", 32'h8, 0, 0, 0, 1, 1); tick;
    drv(1, 0, 1, 0, 3'b000, NONE, 0, 32'hFFFF_FFF4, 0);
    expect_st("jal_top", 32'hFFFF_FFFC, 0, 0, 0, 1, 1); tick;
    chk("pc_plus4_wrap", pc_plus4, 32'h0);
    drv(1, 0, 0, 0, 3'b000, NONE, 0, 0, 0);
    expect_st("pc_wrap", 32'h0, 0, 0, 0, 1, 1); tick;
    drv(0, 0, 0, 0, 3'b000, NONE, 0, 0, 0);
    force dut.taken_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.taken_count_q;
    #1;
    chk("taken_count_preset", taken_count, 32'hFFFF_FFFF);
    drv(1, 1, 0, 0, 3'b000, EQ, 0, 32'h10, 0);
    expect_st("taken_count_wrap", 32'h10, 0, 0, 0, 2, 0); tick;
    drv(1, 1, 0, 0, 3'b000, EQ, 0, 32'h2, 0);
    expect_st("branch_misalign", 32'h10, 1, 1, 32'h10, 2, 0); tick;
    drv(1, 1, 0, 0, 3'b000, EQ, 0, 32'h2, 1);
    expect_st("ack_en_high", 32'h100, 0, 0, 32'h10, 2, 0); tick;
    drv(0, 0, 0, 0, 3'b000, NONE, 0, 0, 0);
    expect_st("epc_holds", 32'h100, 0, 0, 32'h10, 2, 0); tick;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
